// File: rtl/cla_nibble_sequencer_if.sv
// Valid/ready operand and result bundle for cla_nibble_sequencer.
// The sub signal exists only when CLA_SEQ_SUB_EN is defined.
interface cla_nibble_sequencer_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef CLA_SEQ_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;

`ifdef CLA_SEQ_SUB_EN
  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, busy
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, busy
  );
`else
  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, busy
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, busy
  );
`endif
endinterface

// File: rtl/cla_nibble_sequencer.sv
// Multi-cycle WIDTH-bit adder: one shared 4-bit CLA slice walks the operands LSB nibble first.
// Define CLA_SEQ_SUB_EN to add the sub input (a - b via ~b and carry-in of 1).
module cla_nibble_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  cla_nibble_sequencer_if.slave  bus
);
  localparam int NIB   = WIDTH / 4;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  // Operand nibbles laid out as arrays so the slice input is a plain indexed mux.
  logic [3:0]       a_nibs [NIB];
  logic [3:0]       b_nibs [NIB];
  logic [NIB-1:0]   nib_sel;

  genvar gi;
  generate
    for (gi = 0; gi < NIB; gi++) begin : g_nib
      assign a_nibs[gi]  = a_q[4*gi +: 4];
      assign b_nibs[gi]  = b_q[4*gi +: 4];
      assign nib_sel[gi] = (idx_q == IDX_W'(gi));
    end
  endgenerate

  logic [3:0] nib_a, nib_b, nib_g, nib_p, nib_s;
  logic [4:0] nib_c;

  assign nib_a = a_nibs[idx_q];
  assign nib_b = b_nibs[idx_q];
  assign nib_g = nib_a & nib_b;
  assign nib_p = nib_a | nib_b;

  // Fully flattened look-ahead: every carry depends only on g, p and the stored carry.
  assign nib_c[0] = carry_q;
  assign nib_c[1] = nib_g[0]
                  | (nib_p[0] & carry_q);
  assign nib_c[2] = nib_g[1]
                  | (nib_p[1] & nib_g[0])
                  | (nib_p[1] & nib_p[0] & carry_q);
  assign nib_c[3] = nib_g[2]
                  | (nib_p[2] & nib_g[1])
                  | (nib_p[2] & nib_p[1] & nib_g[0])
                  | (nib_p[2] & nib_p[1] & nib_p[0] & carry_q);
  assign nib_c[4] = nib_g[3]
                  | (nib_p[3] & nib_g[2])
                  | (nib_p[3] & nib_p[2] & nib_g[1])
                  | (nib_p[3] & nib_p[2] & nib_p[1] & nib_g[0])
                  | (nib_p[3] & nib_p[2] & nib_p[1] & nib_p[0] & carry_q);

  generate
    for (gi = 0; gi < 4; gi++) begin : g_sum_bit
      assign nib_s[gi] = nib_a[gi] ^ nib_b[gi] ^ nib_c[gi];
    end
  endgenerate

  // Operand capture; subtraction folds into the same adder as a + ~b + 1.
  logic [WIDTH-1:0] cap_b;
  logic             cap_carry;

`ifdef CLA_SEQ_SUB_EN
  assign cap_b     = bus.sub ? ~bus.b : bus.b;
  assign cap_carry = bus.sub ? 1'b1 : bus.cin;
`else
  assign cap_b     = bus.b;
  assign cap_carry = bus.cin;
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    idx_d   = idx_q;

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = cap_b;
          carry_d = cap_carry;
          idx_d   = '0;
          sum_d   = '0;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        for (int i = 0; i < NIB; i++) begin
          if (nib_sel[i]) begin
            sum_d[4*i +: 4] = nib_s;
          end
        end
        carry_d = nib_c[4];
        if (idx_q == LAST_IDX) begin
          cout_d  = nib_c[4];
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end

      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      idx_q   <= idx_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
endmodule

// File: tb/tb_cla_nibble_sequencer.sv
// Bench for cla_nibble_sequencer: directed vector table, backpressure/reset sequences,
// and randomized traffic against an arithmetic scoreboard. Sub tests need CLA_SEQ_SUB_EN.
module tb_cla_nibble_sequencer;
  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;
  localparam int NOPS  = 1000;
  localparam int MAXC  = 60000;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  cla_nibble_sequencer_if #(.WIDTH(WIDTH)) bus ();

  cla_nibble_sequencer #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] exp_sum;
    logic        exp_cout;
  } vec_t;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic [16:0] e;
  } exp_t;

  int   total = 0;
  int   bad   = 0;
  vec_t vecs[$];
  exp_t sb_q[$];
  int   got   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ops(input logic [15:0] a, input logic [15:0] b,
                           input logic cin, input logic sub);
    bus.a   = a;
    bus.b   = b;
    bus.cin = cin;
`ifdef CLA_SEQ_SUB_EN
    bus.sub = sub;
`else
    if (sub) $display("note: sub requested in add-only build");
`endif
  endtask

  // Accept one operation and wait (bounded) for out_valid; returns the cycle count.
  task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                          input logic sub, output int lat);
    chk("in_ready_idle", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    drive_ops(a, b, cin, sub);
    tick();
    bus.in_valid = 1'b0;
    drive_ops(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'b0);
    chk("busy_after_accept", 32'(bus.busy), 32'd1);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic finish_op();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("out_valid_drop", 32'(bus.out_valid), 32'd0);
    chk("in_ready_after", 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    int          lat;
    logic [15:0] s_hold;
    logic        c_hold;

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    drive_ops(16'h0, 16'h0, 1'b0, 1'b0);

    vecs.push_back('{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0});
    vecs.push_back('{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1});
    vecs.push_back('{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0});
    vecs.push_back('{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0});
    vecs.push_back('{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1});
    vecs.push_back('{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1});
    vecs.push_back('{16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0});
    vecs.push_back('{16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0});
`ifdef CLA_SEQ_SUB_EN
    vecs.push_back('{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0});
    vecs.push_back('{16'h1234, 16'h0234, 1'b1, 1'b1, 16'h1000, 1'b1});
    vecs.push_back('{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0});
`endif

    // Reset state
    #2 rst_n = 1'b0;
    #20;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_sum", 32'(bus.sum), 32'd0);
    chk("rst_cout", 32'(bus.cout), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    rst_n = 1'b1;
    tick();

    // Directed vector table
    for (int i = 0; i < vecs.size(); i++) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, lat);
      $display("vec %0d a=%h b=%h cin=%0d sub=%0d -> sum=%h cout=%0d lat=%0d",
               i, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, bus.sum, bus.cout, lat);
      chk("vec_latency", 32'(lat), 32'(NIB));
      chk("vec_sum", 32'(bus.sum), 32'(vecs[i].exp_sum));
      chk("vec_cout", 32'(bus.cout), 32'(vecs[i].exp_cout));
      finish_op();
    end

    // Backpressure: result frozen, in_valid pulse ignored
    start_op(16'h00FF, 16'h0001, 1'b0, 1'b0, lat);
    chk("bp_latency", 32'(lat), 32'(NIB));
    s_hold = bus.sum;
    c_hold = bus.cout;
    chk("bp_sum", 32'(s_hold), 32'h0100);
    for (int k = 0; k < 5; k++) begin
      if (k == 2) begin
        bus.in_valid = 1'b1;
        drive_ops(16'hAAAA, 16'h5555, 1'b1, 1'b0);
      end
      tick();
      bus.in_valid = 1'b0;
      chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_sum_stable", 32'(bus.sum), 32'(s_hold));
      chk("bp_cout_stable", 32'(bus.cout), 32'(c_hold));
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
    end
    finish_op();
    $display("backpressure a=00ff b=0001 -> sum=%h cout=%0d", s_hold, c_hold);
    tick();
    chk("bp_pulse_ignored", 32'(bus.busy), 32'd0);

    // Reset mid-RUN abandons the partial result
    bus.in_valid = 1'b1;
    drive_ops(16'h1111, 16'h2222, 1'b0, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_sum", 32'(bus.sum), 32'd0);
    #3 rst_n = 1'b1;
    tick();
    start_op(16'h1234, 16'h4321, 1'b0, 1'b0, lat);
    $display("after reset a=1234 b=4321 -> sum=%h cout=%0d", bus.sum, bus.cout);
    chk("post_rst_latency", 32'(lat), 32'(NIB));
    chk("post_rst_sum", 32'(bus.sum), 32'h5555);
    chk("post_rst_cout", 32'(bus.cout), 32'd0);
    finish_op();

    // Randomized traffic with stalls on both sides
    fork
      begin : drv
        logic [15:0] ra, rb;
        logic        rc, rs, rdy, acc;
        logic [16:0] e;
        int          guard;
        for (int n = 0; n < NOPS; n++) begin
          repeat ($urandom_range(0, 2)) tick();
          ra = 16'($urandom);
          rb = 16'($urandom);
          rc = 1'($urandom_range(0, 1));
`ifdef CLA_SEQ_SUB_EN
          rs = 1'($urandom_range(0, 1));
`else
          rs = 1'b0;
`endif
          bus.in_valid = 1'b1;
          drive_ops(ra, rb, rc, rs);
          acc   = 1'b0;
          guard = 0;
          while (!acc && guard < 100) begin
            rdy = bus.in_ready;
            tick();
            guard++;
            if (rdy) acc = 1'b1;
          end
          bus.in_valid = 1'b0;
          if (!acc) begin
            chk("rand_accept_timeout", 32'd0, 32'd1);
            break;
          end
          if (rs) e = {(ra >= rb), 16'(ra - rb)};
          else    e = 17'(ra) + 17'(rb) + 17'(rc);
          sb_q.push_back('{ra, rb, rs, e});
        end
      end
      begin : mon
        int          cyc;
        logic        hs;
        logic [15:0] ms;
        logic        mc;
        exp_t        x;
        cyc = 0;
        while (got < NOPS && cyc < MAXC) begin
          bus.out_ready = ($urandom_range(0, 3) != 0);
          hs = bus.out_valid && bus.out_ready;
          ms = bus.sum;
          mc = bus.cout;
          tick();
          cyc++;
          if (hs) begin
            got++;
            if (sb_q.size() == 0) begin
              chk("rand_duplicate", 32'd1, 32'd0);
            end else begin
              x = sb_q.pop_front();
              $display("rand %0d a=%h b=%h sub=%0d -> sum=%h cout=%0d", got, x.a, x.b, x.sub, ms, mc);
              chk("rand_result", 32'({mc, ms}), 32'(x.e));
            end
          end
        end
        bus.out_ready = 1'b0;
        chk("rand_count", 32'(got), 32'(NOPS));
      end
    join
    chk("rand_leftover", 32'(sb_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
